// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one xor/and half-adder pair per stage, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a-b via ~b and carry-in of 1.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_shift;
  logic [WIDTH-1:0]   r_a_q;
  logic [WIDTH-1:0]   r_b_q;
  logic [WIDTH-1:0]   r_sum_q;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_cin_in;
  logic               w_ha1_s;
  logic               w_ha1_c;
  logic               w_ha2_s;
  logic               w_ha2_c;
  logic               w_carry_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = sub | cin & ~sub;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  // Full-adder cell built from two half-adder stages plus an OR for carry
  assign w_ha1_s     = r_a_q[0] ^ r_b_q[0];
  assign w_ha1_c     = r_a_q[0] & r_b_q[0];
  assign w_ha2_s     = w_ha1_s ^ r_carry;
  assign w_ha2_c     = w_ha1_s & r_carry;
  assign w_carry_nxt = w_ha1_c | w_ha2_c;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers; sum_q and carry double as the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_q   <= '0;
      r_b_q   <= '0;
      r_sum_q <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_q   <= a;
      r_b_q   <= w_b_in;
      r_sum_q <= '0;
      r_carry <= w_cin_in;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_a_q   <= {1'b0, r_a_q[WIDTH-1:1]};
      r_b_q   <= {1'b0, r_b_q[WIDTH-1:1]};
      r_sum_q <= {w_ha2_s, r_sum_q[WIDTH-1:1]};
      r_carry <= w_carry_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Handshake flags registered from the next state so they track r_state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum_q;
  assign cout      = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8), with hand-computed expectations.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_pass = 0;
  int n_total = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; drive and sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full add transaction: accept, wait for out_valid with a bound, check latency/result, retire
  task automatic do_add(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic icin, input logic isub,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int lat;
    a = ia; b = ib; cin = icin; in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = isub;
`else
    if (isub) $display("note: sub ignored in add-only build");
`endif
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3 * WIDTH) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // rst together with in_valid: nothing captured
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid_ready", 32'(in_ready), 32'd1);
    check("rst_vs_valid_busy", 32'(busy), 32'd0);
    step();
    check("rst_vs_valid_still_idle", 32'(busy), 32'd0);

    // Test 1 + 3: basic add, exact latency, then backpressure in DONE
    a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      step();
      check("t1_no_early_valid", 32'(out_valid), 32'd0);
    end
    step();
    check("t1_valid_at_width", 32'(out_valid), 32'd1);
    check("t1_sum", 32'(sum), 32'h8D);
    check("t1_cout", 32'(cout), 32'd0);
    held_sum = sum; held_cout = cout;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_sum", 32'(sum), 32'(held_sum));
      check("t3_hold_cout", 32'(cout), 32'(held_cout));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_release_ready", 32'(in_ready), 32'd1);
    check("t3_release_valid", 32'(out_valid), 32'd0);
    check("t3_release_busy", 32'(busy), 32'd0);
    check("t3_idle_keeps_sum", 32'(sum), 32'h8D);
    step();

    // Test 2: carry boundary cases and extra patterns
    do_add("t2_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    step();
    do_add("t2_ff_00_c1", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    step();
    do_add("p_80_80_c1", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);
    step();
    do_add("p_12_34_c1", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);
    step();

    // Test 4: in_valid during RUN/DONE is ignored
    a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 8'h11; b = 8'h22; cin = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
      step();
    end
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_sum", 32'(sum), 32'h8D);
    check("t4_cout", 32'(cout), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_back_idle", 32'(in_ready), 32'd1);
    step();

    // Test 5: reset in the 3rd RUN cycle aborts the add
    a = 8'hF0; b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      step();
      check("t5_no_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    // Test 6: subtraction, cout=1 means no borrow
    do_add("t6_10_m_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    step();
    do_add("t6_01_m_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    step();
    do_add("t6_sub0_add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
